// File: rtl/ball_pkg.sv
// Shared types and constants for the multi-ball renderer: float scale factors,
// the load FSM state encoding and the per-ball pixel-space parameter record.
package ball_pkg;

    // IEEE-754 single-precision scale factors used when converting body params
    localparam logic [31:0] FLOAT2   = 32'h4000_0000;
    localparam logic [31:0] FLOAT10  = 32'h4120_0000;
    localparam logic [31:0] FLOAT100 = 32'h42C8_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CONV,
        COMMIT
    } load_state_t;

    // Pixel-space description of one ball; r == 0 means the ball is disabled
    typedef struct packed {
        logic signed [31:0] cx;
        logic signed [31:0] cy;
        logic signed [31:0] r;
    } ball_param_t;

endpackage

// File: rtl/ball_param_conv.sv
// Converts one ball's float parameters plus the camera Z shift into pixel-space
// centre and clamped radius. Purely combinational; the load FSM time-shares one
// instance across all balls.
module ball_param_conv
    import ball_pkg::*;
#(
    parameter int X_OFFSET   = 320,
    parameter int Y_OFFSET   = 240,
    parameter int Z_BIAS     = 10,
    parameter int MAX_RADIUS = 80
) (
    input  logic        [31:0] radius,
    input  logic        [31:0] posX,
    input  logic        [31:0] posY,
    input  logic        [31:0] posZ,
    input  logic signed [31:0] shift,
    output ball_param_t        param
);

    // Float multiply (round to nearest even) followed by truncation toward zero.
    // Zero/denormal operands give 0; magnitudes beyond 31 bits saturate.
    function automatic logic signed [31:0] fpMulInt(input logic [31:0] a, input logic [31:0] b);
        logic [23:0]        ma;
        logic [23:0]        mb;
        logic [47:0]        prod;
        logic [24:0]        mant;
        logic               guardBit;
        logic               stickyBit;
        int                 expo;
        int                 sh;
        logic [63:0]        mag;
        logic signed [31:0] res;
        ma   = {1'b1, a[22:0]};
        mb   = {1'b1, b[22:0]};
        prod = ma * mb;
        expo = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            mant      = {1'b0, prod[47:24]};
            guardBit  = prod[23];
            stickyBit = |prod[22:0];
            expo      = expo + 1;
        end else begin
            mant      = {1'b0, prod[46:23]};
            guardBit  = prod[22];
            stickyBit = |prod[21:0];
        end
        if (guardBit && (stickyBit || mant[0])) begin
            mant = mant + 25'd1;
        end
        if (mant[24]) begin
            mant = mant >> 1;
            expo = expo + 1;
        end
        sh = expo - 150;
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0) || (expo < 127)) begin
            mag = 64'd0;
        end else if (sh > 7) begin
            mag = 64'h0000_0000_7FFF_FFFF;
        end else if (sh >= 0) begin
            mag = {39'd0, mant} << sh;
        end else begin
            mag = {39'd0, mant} >> (-sh);
        end
        res = signed'(mag[31:0]);
        if (a[31] ^ b[31]) begin
            res = -res;
        end
        return res;
    endfunction

    logic signed [31:0] intRad;
    logic signed [31:0] intPosX;
    logic signed [31:0] intPosY;
    logic signed [31:0] intPosZ;
    logic signed [31:0] adj;

    // Scale each float to pixel units and derive the depth-adjusted radius
    always_comb begin
        intRad  = fpMulInt(radius, FLOAT10);
        intPosX = fpMulInt(posX, FLOAT100);
        intPosY = fpMulInt(posY, FLOAT100);
        intPosZ = fpMulInt(posZ, FLOAT2);
        adj     = intPosZ + Z_BIAS + shift + intRad;
        param.cx = intPosX + X_OFFSET;
        param.cy = intPosY + Y_OFFSET;
        if (radius == 32'h0) begin
            param.r = 32'sd0;
        end else if (adj < 0) begin
            param.r = 32'sd1;
        end else if (adj > MAX_RADIUS) begin
            param.r = MAX_RADIUS;
        end else begin
            param.r = adj;
        end
    end

endmodule

// File: rtl/ball_array_render.sv
// Per-pixel hit tester for N_BALLS bodies. A load FSM reads every ball from the
// body register file once per frame, converts it, and commits the whole set at
// once; a 2-stage pipeline tests DrawX/DrawY against all balls in parallel.
// Optional build macro BALL_DEPTH_SORT_EN: on overlap the largest-radius hit wins
// (ties to lowest index) instead of plain lowest-index priority.
module ball_array_render
    import ball_pkg::*;
#(
    parameter int N_BALLS    = 8,
    parameter int IDX_W      = (N_BALLS > 1) ? $clog2(N_BALLS) : 1,
    parameter int X_OFFSET   = 320,
    parameter int Y_OFFSET   = 240,
    parameter int Z_BIAS     = 10,
    parameter int MAX_RADIUS = 80
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_start,
    input  logic signed [31:0]   relative_shift_z,
    output logic [IDX_W-1:0]     ball_rd_idx,
    input  logic [31:0]          ball_rd_radius,
    input  logic [31:0]          ball_rd_posX,
    input  logic [31:0]          ball_rd_posY,
    input  logic [31:0]          ball_rd_posZ,
    input  logic [31:0]          DrawX,
    input  logic [31:0]          DrawY,
    input  logic                 pix_valid,
    output logic                 is_ball,
    output logic [IDX_W-1:0]     ball_idx,
    output logic                 load_busy
);

    load_state_t        state;
    load_state_t        nextState;
    logic [IDX_W-1:0]   loadIdx;
    logic               lastBall;
    logic               captureEn;
    logic               shadowWe;
    logic               commitEn;
    logic               idxInc;
    logic               loadBusy;
    logic signed [31:0] shiftReg;
    logic [31:0]        capRad;
    logic [31:0]        capPosX;
    logic [31:0]        capPosY;
    logic [31:0]        capPosZ;
    ball_param_t        convParam;
    ball_param_t        shadowBank [N_BALLS];
    ball_param_t        activeBank [N_BALLS];

    logic signed [31:0] s1Dx [N_BALLS];
    logic signed [31:0] s1Dy [N_BALLS];
    logic signed [31:0] s1R  [N_BALLS];
    logic               s1Valid;
    logic [N_BALLS-1:0] hitVec;
    logic               winFound;
    logic [IDX_W-1:0]   winIdx;
`ifdef BALL_DEPTH_SORT_EN
    logic signed [31:0] winR;
`endif

    assign lastBall    = (loadIdx == IDX_W'(N_BALLS - 1));
    assign ball_rd_idx = loadIdx;
    assign load_busy   = loadBusy;

    ball_param_conv #(
        .X_OFFSET   (X_OFFSET),
        .Y_OFFSET   (Y_OFFSET),
        .Z_BIAS     (Z_BIAS),
        .MAX_RADIUS (MAX_RADIUS)
    ) uConv (
        .radius (capRad),
        .posX   (capPosX),
        .posY   (capPosY),
        .posZ   (capPosZ),
        .shift  (shiftReg),
        .param  (convParam)
    );

    // Load FSM state register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Load FSM sequencing; a new frame_start always restarts from ball 0 and suppresses commit
    always_comb begin
        nextState = state;
        loadBusy  = 1'b0;
        captureEn = 1'b0;
        shadowWe  = 1'b0;
        commitEn  = 1'b0;
        idxInc    = 1'b0;
        case (state)
            IDLE: begin
            end
            REQ: begin
                loadBusy  = 1'b1;
                nextState = WAIT;
            end
            WAIT: begin
                loadBusy  = 1'b1;
                captureEn = 1'b1;
                nextState = CONV;
            end
            CONV: begin
                loadBusy = 1'b1;
                shadowWe = 1'b1;
                if (lastBall) begin
                    nextState = COMMIT;
                end else begin
                    idxInc    = 1'b1;
                    nextState = REQ;
                end
            end
            COMMIT: begin
                loadBusy  = 1'b1;
                commitEn  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (frame_start) begin
            nextState = REQ;
            captureEn = 1'b0;
            shadowWe  = 1'b0;
            commitEn  = 1'b0;
            idxInc    = 1'b0;
        end
    end

    // Load datapath: read index, captured read data, shadow bank and atomic commit to active bank
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            loadIdx  <= '0;
            shiftReg <= '0;
            capRad   <= '0;
            capPosX  <= '0;
            capPosY  <= '0;
            capPosZ  <= '0;
            for (int i = 0; i < N_BALLS; i++) begin
                shadowBank[i] <= '0;
                activeBank[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                loadIdx  <= '0;
                shiftReg <= relative_shift_z;
            end else if (commitEn) begin
                loadIdx <= '0;
            end else if (idxInc) begin
                loadIdx <= loadIdx + 1'b1;
            end
            if (captureEn) begin
                capRad  <= ball_rd_radius;
                capPosX <= ball_rd_posX;
                capPosY <= ball_rd_posY;
                capPosZ <= ball_rd_posZ;
            end
            if (shadowWe) begin
                shadowBank[loadIdx] <= convParam;
            end
            if (commitEn) begin
                for (int i = 0; i < N_BALLS; i++) begin
                    activeBank[i] <= shadowBank[i];
                end
            end
        end
    end

    // Pixel stage 1: offsets from every active ball centre, plus its radius
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1Valid <= 1'b0;
            for (int i = 0; i < N_BALLS; i++) begin
                s1Dx[i] <= '0;
                s1Dy[i] <= '0;
                s1R[i]  <= '0;
            end
        end else begin
            s1Valid <= pix_valid;
            for (int i = 0; i < N_BALLS; i++) begin
                s1Dx[i] <= $signed(DrawX) - activeBank[i].cx;
                s1Dy[i] <= $signed(DrawY) - activeBank[i].cy;
                s1R[i]  <= activeBank[i].r;
            end
        end
    end

    // Squared squares never exceed 2^62 each, so their unsigned 64-bit sum cannot wrap
    for (genvar g = 0; g < N_BALLS; g++) begin : gHit
        logic signed [63:0] dxW;
        logic signed [63:0] dyW;
        logic signed [63:0] rW;
        logic [63:0]        dxSq;
        logic [63:0]        dySq;
        logic [63:0]        rSq;
        assign dxW  = {{32{s1Dx[g][31]}}, s1Dx[g]};
        assign dyW  = {{32{s1Dy[g][31]}}, s1Dy[g]};
        assign rW   = {{32{s1R[g][31]}}, s1R[g]};
        assign dxSq = unsigned'(dxW * dxW);
        assign dySq = unsigned'(dyW * dyW);
        assign rSq  = unsigned'(rW * rW);
        assign hitVec[g] = (s1R[g] != 32'sd0) && ((dxSq + dySq) <= rSq);
    end

`ifdef BALL_DEPTH_SORT_EN
    // Stage 2 winner: largest radius among hits, strict compare keeps the lower index on ties
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        winR     = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            if (hitVec[i] && (!winFound || (s1R[i] > winR))) begin
                winFound = 1'b1;
                winIdx   = IDX_W'(i);
                winR     = s1R[i];
            end
        end
    end
`else
    // Stage 2 winner: fixed priority, lowest hit index wins
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        for (int i = N_BALLS - 1; i >= 0; i--) begin
            if (hitVec[i]) begin
                winFound = 1'b1;
                winIdx   = IDX_W'(i);
            end
        end
    end
`endif

    // Pixel stage 2 output register; invalid pixels report no ball
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            is_ball  <= 1'b0;
            ball_idx <= '0;
        end else begin
            is_ball  <= s1Valid && winFound;
            ball_idx <= (s1Valid && winFound) ? winIdx : '0;
        end
    end

endmodule
